// File: rtl/dmem_responder.sv
// Single-port data-memory responder with fixed response latency.
// One request outstanding; loads are sampled and stores committed at acceptance.
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        read_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] data_in,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] data_out,
   output logic        rsp_err
);

   localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] rsp_data;
   logic        rsp_err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic            accept;
   logic [31:0]     offset;
   logic [IDXW-1:0] idx;
   logic            funct3_bad, misalign, range_err, err;
   logic [31:0]     rd_word, load_val, wdata;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic [3:0]      be;

   assign req_ready = (state == IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign offset    = req_addr - BASE_ADDR;
   assign idx       = offset[IDXW+1:2];
   assign rd_word   = mem[idx];

   always_comb begin
      if (read_write)
         funct3_bad = (req_funct3 > 3'b010);
      else
         funct3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      range_err = (offset >= SPAN);
      err       = funct3_bad || misalign || range_err;
   end

   always_comb begin
      case (req_addr[1:0])
         2'b00:   rd_byte = rd_word[7:0];
         2'b01:   rd_byte = rd_word[15:8];
         2'b10:   rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (req_funct3)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_val = rd_word;
         3'b100:  load_val = {24'h0, rd_byte};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = '0;
      endcase
   end

   // Store data is replicated across lanes so each enabled lane picks its own slice.
   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            wdata = {4{data_in[7:0]}};
            be    = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            wdata = {2{data_in[15:0]}};
            be    = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = data_in;
            be    = '1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (accept && read_write && !err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i])
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_n   = 4'(LATENCY - 1);
               state_n = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1)
               state_n = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_data  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            rsp_err_q <= err;
            rsp_data  <= (err || read_write) ? '0 : load_val;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign data_out  = rsp_valid ? rsp_data : '0;
   assign rsp_err   = rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model,
// plus a LATENCY=1 instance exercised with a short directed sequence.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h0100_0000;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, req_valid, req_ready, read_write, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, data_in, data_out;
   logic [2:0]  req_funct3;

   logic        reset1, req_valid1, req_ready1, read_write1, rsp_valid1, rsp_ready1, rsp_err1;
   logic [31:0] req_addr1, data_in1, data_out1;
   logic [2:0]  req_funct31;

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .read_write(read_write), .req_funct3(req_funct3),
      .data_in(data_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .data_out(data_out), .rsp_err(rsp_err)
   );

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clock(clock), .reset(reset1), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_addr(req_addr1), .read_write(read_write1), .req_funct3(req_funct31),
      .data_in(data_in1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .data_out(data_out1), .rsp_err(rsp_err1)
   );

   logic [7:0] ref_mem [4*DEPTH];
   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, access of 2**size bytes, little-endian.
   function automatic void ref_access(input logic [31:0] a, input logic rw, input logic [2:0] f3,
                                      input logic [31:0] d, output logic err, output logic [31:0] res);
      logic [31:0] off;
      logic        legal;
      int          n;
      off   = a - BASE;
      legal = rw ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      n     = 1 << f3[1:0];
      err   = !legal || ((a % n) != 0) || (off >= 32'(4*DEPTH));
      res   = '0;
      if (!err) begin
         if (rw) begin
            for (int k = 0; k < n; k++) ref_mem[off + k] = d[8*k +: 8];
         end else begin
            for (int k = 0; k < n; k++) res = res | (32'(ref_mem[off + k]) << (8*k));
            if (!f3[2] && n < 4 && res[8*n-1]) res = res | ~((32'd1 << (8*n)) - 32'd1);
         end
      end
   endfunction

   task automatic do_req(input logic [31:0] a, input logic rw, input logic [2:0] f3,
                         input logic [31:0] d, input int stall,
                         output logic [31:0] obs, output logic obs_err);
      logic        exp_err;
      logic [31:0] exp_data;
      int          lat;
      @(negedge clock);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = a; read_write = rw; req_funct3 = f3; data_in = d; rsp_ready = 1'b0;
      ref_access(a, rw, f3, d, exp_err, exp_data);
      @(negedge clock);
      // Busy-phase garbage on the request inputs must be ignored.
      req_valid = 1'($urandom); req_addr = $urandom; read_write = 1'($urandom);
      req_funct3 = 3'($urandom); data_in = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         chk("req_ready_wait", 32'(req_ready), 32'd0);
         @(negedge clock);
         lat++;
      end
      chk("latency", 32'(lat), 32'(LAT));
      obs = data_out; obs_err = rsp_err;
      chk("data_out", data_out, exp_data);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", data_out, exp_data);
         chk("hold_err", 32'(rsp_err), 32'(exp_err));
         chk("req_ready_resp", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      #1 chk("req_ready_rspready", 32'(req_ready), 32'd0);
      @(negedge clock);
      rsp_ready = 1'b0;
      chk("valid_drop", 32'(rsp_valid), 32'd0);
      chk("data_idle", data_out, 32'd0);
      chk("err_idle", 32'(rsp_err), 32'd0);
      chk("req_ready_back", 32'(req_ready), 32'd1);
   endtask

   logic [31:0] obs;
   logic        obs_err;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; read_write = 1'b0;
      req_funct3 = '0; data_in = '0; rsp_ready = 1'b0;
      reset1 = 1'b1; req_valid1 = 1'b0; req_addr1 = '0; read_write1 = 1'b0;
      req_funct31 = '0; data_in1 = '0; rsp_ready1 = 1'b0;
      repeat (3) begin
         @(negedge clock);
         chk("rst_valid", 32'(rsp_valid), 32'd0);
         chk("rst_data", data_out, 32'd0);
         chk("rst_err", 32'(rsp_err), 32'd0);
         chk("rst_ready", 32'(req_ready), 32'd0);
      end
      reset = 1'b0; reset1 = 1'b0;

      for (int w = 0; w < DEPTH; w++)
         do_req(BASE + 32'(4*w), 1'b1, 3'b010, $urandom, 0, obs, obs_err);

      do_req(32'h0100_0010, 1'b1, 3'b010, 32'hDEADBEEF, 0, obs, obs_err);
      do_req(32'h0100_0010, 1'b0, 3'b010, 32'h0, 0, obs, obs_err);
      chk("lw_deadbeef", obs, 32'hDEADBEEF);
      do_req(32'h0100_0013, 1'b1, 3'b000, 32'h0000_0080, 0, obs, obs_err);
      do_req(32'h0100_0013, 1'b0, 3'b000, 32'h0, 0, obs, obs_err);
      chk("lb_80", obs, 32'hFFFF_FF80);
      do_req(32'h0100_0013, 1'b0, 3'b100, 32'h0, 0, obs, obs_err);
      chk("lbu_80", obs, 32'h0000_0080);
      do_req(32'h0100_0010, 1'b0, 3'b010, 32'h0, 5, obs, obs_err);
      chk("lw_80adbeef", obs, 32'h80AD_BEEF);
      do_req(32'h0100_0011, 1'b0, 3'b001, 32'h0, 0, obs, obs_err);
      chk("lh_misalign_err", 32'(obs_err), 32'd1);
      do_req(32'h0100_1000, 1'b1, 3'b010, 32'h5555_AAAA, 0, obs, obs_err);
      chk("sw_range_err", 32'(obs_err), 32'd1);
      do_req(32'h0100_0FFC, 1'b0, 3'b010, 32'h0, 0, obs, obs_err);

      // Reset one cycle after a load is accepted aborts the response.
      @(negedge clock);
      req_valid = 1'b1; req_addr = BASE; read_write = 1'b0; req_funct3 = 3'b010;
      @(negedge clock);
      req_valid = 1'b0; reset = 1'b1;
      repeat (2) begin
         @(negedge clock);
         chk("abort_valid", 32'(rsp_valid), 32'd0);
         chk("abort_ready", 32'(req_ready), 32'd0);
      end
      // Reset wins over a simultaneous store: nothing may be written.
      req_valid = 1'b1; req_addr = BASE + 32'h20; read_write = 1'b1; req_funct3 = 3'b010;
      data_in = 32'h1234_5678;
      @(negedge clock);
      req_valid = 1'b0; reset = 1'b0;
      #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
      repeat (4) begin
         @(negedge clock);
         chk("abort_no_valid", 32'(rsp_valid), 32'd0);
      end
      do_req(BASE + 32'h20, 1'b0, 3'b010, 32'h0, 0, obs, obs_err);

      for (int t = 0; t < 400; t++) begin
         logic [31:0] a;
         int          r;
         r = $urandom_range(0, 9);
         if (r == 0)      a = BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 7));
         else if (r == 1) a = BASE - 32'($urandom_range(1, 8));
         else             a = BASE + 32'($urandom_range(0, 4*DEPTH-1));
         do_req(a, 1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3), obs, obs_err);
      end

      // LATENCY = 1 instance: response in the cycle right after acceptance.
      @(negedge clock);
      req_valid1 = 1'b1; req_addr1 = BASE + 32'h4; read_write1 = 1'b1;
      req_funct31 = 3'b010; data_in1 = 32'hA5A5_1234;
      @(negedge clock);
      req_valid1 = 1'b0;
      chk("l1_sw_valid", 32'(rsp_valid1), 32'd1);
      chk("l1_sw_err", 32'(rsp_err1), 32'd0);
      chk("l1_sw_data", data_out1, 32'd0);
      rsp_ready1 = 1'b1;
      @(negedge clock);
      rsp_ready1 = 1'b0;
      chk("l1_idle", 32'(rsp_valid1), 32'd0);
      req_valid1 = 1'b1; read_write1 = 1'b0;
      @(negedge clock);
      req_valid1 = 1'b0;
      chk("l1_lw_valid", 32'(rsp_valid1), 32'd1);
      chk("l1_lw_data", data_out1, 32'hA5A5_1234);
      rsp_ready1 = 1'b1;
      @(negedge clock);
      rsp_ready1 = 1'b0;
      chk("l1_lw_drop", 32'(rsp_valid1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0100_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-003 SHALL have parameter LATENCY, default 2, number of cycles from request acceptance to response; legal range 1..15.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  core presents a data-memory request.
REQ-007 SHALL have port req_ready  out  1  responder can accept a request this cycle.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port read_write  in  1  0 = load, 1 = store.
REQ-010 SHALL have port req_funct3  in  3  access size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-011 SHALL have port data_in  in  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  core accepts the response.
REQ-014 SHALL have port data_out  out  32  load result, extended to 32 bits.
REQ-015 SHALL have port rsp_err  out  1  request was misaligned, out of range or had an illegal funct3.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP; at most one request is outstanding.
REQ-017 SHALL drive req_ready = 1 only in IDLE while reset is low.
REQ-018 SHALL accept a request on an edge where req_valid && req_ready, latching the request and loading the latency counter with LATENCY-1.
REQ-019 SHALL transition from IDLE to RESP on acceptance when LATENCY == 1, and to WAIT otherwise.
REQ-020 SHALL decrement the counter in WAIT and enter RESP on the edge where the counter equals 1, so rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-021 SHALL hold rsp_valid, data_out and rsp_err stable in RESP until rsp_ready is high, then return to IDLE on that edge.
REQ-022 SHALL keep req_ready low in RESP even when rsp_ready is high, so requests cannot be issued back-to-back and the minimum spacing is LATENCY+1 cycles.
REQ-023 SHALL flag an error when any of these holds: funct3 is illegal (any store with funct3 not in {000,001,010}, or any load with funct3 in {011,110,111}); a half access has addr[0] = 1; a word access has addr[1:0] != 0; or (addr - BASE_ADDR) >= 4*DEPTH_WORDS.
REQ-024 SHALL commit a non-error store at the acceptance edge, writing only the addressed lanes: SB writes lane addr[1:0] with data_in[7:0]; SH writes lanes addr[1]*2 and +1 with data_in[15:0]; SW writes all four lanes.
REQ-025 SHALL sample load data at the acceptance edge and return it in RESP: the addressed byte or half sign-extended for LB/LH and zero-extended for LBU/LHU, or the full word for LW.
REQ-026 SHALL return data_out = 0 for stores and for errored requests.
REQ-027 SHALL make no storage change for an errored store; rsp_err = 1 and the response timing is identical to the success case.
REQ-028 SHALL drive data_out = 0 and rsp_err = 0 whenever rsp_valid = 0.
REQ-029 SHALL ignore the request inputs outside IDLE.

Reset
REQ-030 SHALL, on an edge with reset high, enter IDLE with counter = 0, rsp_valid = 0, data_out = 0, rsp_err = 0 and req_ready = 0 during that cycle.
REQ-031 SHALL abort any pending response when reset is asserted mid-operation; a store already committed at acceptance is not undone.
REQ-032 SHALL leave storage contents unaffected by reset; initial contents are undefined.
REQ-033 SHALL give reset priority over a simultaneous request or rsp_ready.

Verification
REQ-034 SHALL cover: SW 0xDEADBEEF to 0x0100_0010, then LW from the same address -> rsp_valid 2 cycles after each acceptance, load data_out = 0xDEADBEEF, rsp_err = 0.
REQ-035 SHALL cover: SB 0x80 to 0x0100_0013, then LB and LBU from that address -> 0xFFFFFF80 and 0x00000080, and LW from 0x0100_0010 returns 0x80ADBEEF.
REQ-036 SHALL cover: LH from 0x0100_0011 and SW to 0x0100_1000 -> rsp_err = 1, data_out = 0, and a subsequent LW from 0x0100_0FFC is unchanged.
REQ-037 SHALL cover: rsp_ready held low for 5 cycles in RESP -> rsp_valid and data stay stable, req_ready stays 0, and the FSM returns to IDLE on the edge where rsp_ready = 1.
REQ-038 SHALL cover: reset asserted one cycle after a load is accepted -> rsp_valid never rises, and req_ready = 1 on the first cycle after reset deasserts.
REQ-039 SHALL cover: LATENCY = 1 build -> rsp_valid is high in the cycle immediately after acceptance.
